mem_port_arbiter: RTL

- Shares the single 4-byte-lane memory port between the core's instruction-fetch path and its load/store path.
- Sequences each access over a fixed-latency memory, drives the address, write data and write-enable, and returns the read word.
- Asserts a stall to the core while any access is outstanding.
- Sits between mips_core (fetch and data requesters) and the memory model.

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 4-byte-lane, fixed-latency memory port between the
//            core's instruction-fetch requester and its load/store requester.
//            Each granted access runs IDLE -> BUSY (MEM_LAT cycles) -> DONE.
//            The owner's done strobe pulses in DONE, and the read word is
//            captured on the last BUSY cycle. Byte packing is big-endian.
// Ports    : clk, rst_b (synchronous, active-high despite the name), halted
//            fetch side : if_req, if_addr, if_done, if_rdata
//            data side  : d_req, d_we, d_addr, d_wdata, d_done, d_rdata
//            core       : stall
//            memory     : mem_addr, mem_data_in[0:3], mem_data_out[0:3],
//                         mem_write_en
// Options  : MEM_ARB_RR_EN - round-robin arbitration on contention instead
//            of fixed data priority (default build: undefined).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,  // access latency in cycles, 1..15
    parameter int CNT_W   = 4   // 2**CNT_W must exceed MEM_LAT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in  [0:3],
    input  logic [7:0]  mem_data_out [0:3],
    output logic        mem_write_en
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic c_OWN_F = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_d_rdata;
    logic             w_grant;
    logic             w_grant_d;
    logic [31:0]      w_rword;

`ifdef MEM_ARB_RR_EN
    logic             r_last_owner;
`endif

    // Big-endian: lane 0 carries the most significant byte.
    assign w_rword = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};

    // ------------------------------------------------------------------------
    // Arbitration: only evaluated in IDLE and never while the core is halted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == c_IDLE && !halted) begin
`ifdef MEM_ARB_RR_EN
            if (d_req && if_req) begin
                // On contention the requester that did not win last time goes.
                w_grant   = 1'b1;
                w_grant_d = (r_last_owner != c_OWN_D);
            end else if (d_req) begin
                w_grant   = 1'b1;
                w_grant_d = 1'b1;
            end else if (if_req) begin
                w_grant   = 1'b1;
            end
`else
            if (d_req) begin
                w_grant   = 1'b1;
                w_grant_d = 1'b1;
            end else if (if_req) begin
                w_grant   = 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        if_done      = 1'b0;
        d_done       = 1'b0;
        mem_write_en = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = c_BUSY;
                end
            end
            c_BUSY: begin
                mem_write_en = r_we;
                if (r_cnt == '0) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if_done     = (r_owner == c_OWN_F);
                d_done      = (r_owner == c_OWN_D);
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: request latch, latency counter, read-word capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_cnt      <= '0;
            r_owner    <= c_OWN_D;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_grant) begin
            // Requests are latched so later changes on the request bus are ignored.
            r_owner <= w_grant_d ? c_OWN_D : c_OWN_F;
            r_addr  <= w_grant_d ? d_addr : if_addr;
            r_we    <= w_grant_d & d_we;
            r_cnt   <= c_CNT_LOAD;
            if (w_grant_d) begin
                r_wdata <= d_wdata;
            end
        end else if (r_state == c_BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end else if (!r_we) begin
                if (r_owner == c_OWN_D) begin
                    r_d_rdata <= w_rword;
                end else begin
                    r_if_rdata <= w_rword;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_last_owner <= c_OWN_F;
        end else if (w_grant) begin
            r_last_owner <= w_grant_d ? c_OWN_D : c_OWN_F;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign mem_addr = r_addr;
    assign stall    = (r_state != c_IDLE) | ((if_req | d_req) & ~halted);

    always_comb begin
        mem_data_in[0] = r_wdata[31:24];
        mem_data_in[1] = r_wdata[23:16];
        mem_data_in[2] = r_wdata[15:8];
        mem_data_in[3] = r_wdata[7:0];
    end

endmodule
`default_nettype wire
